// File: rtl/onij_gather_sequencer.sv
// onij_gather_sequencer: for each of the 16 pixels of a 4x4 output tile, reads the
// 9 kernel-tap psum words (3x3 kernel over a 6x6 input tile), sums them lane-wise
// and presents the result on a valid/ready output port with optional ReLU.
module onij_gather_sequencer #(
  parameter int unsigned COL     = 8,
  parameter int unsigned PSUM_BW = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     psum_ren,
  output logic [8:0]               psum_addr,
  input  logic [COL*PSUM_BW-1:0]   psum_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COL*PSUM_BW-1:0]   out_data,
  output logic [3:0]               out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DATA_W = COL * PSUM_BW;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned KIJ_W  = 4;
  localparam int unsigned ONIJ_W = 4;

  localparam logic [KIJ_W-1:0]  KIJ_LAST  = KIJ_W'(8);
  localparam logic [ONIJ_W-1:0] ONIJ_LAST = ONIJ_W'(15);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [KIJ_W-1:0]    kij, kij_nxt;
  logic [ONIJ_W-1:0]   o_nij, o_nij_nxt;
  logic                relu_q, relu_nxt;

  logic                rd_pend;
  logic                rd_first;
  logic [DATA_W-1:0]   acc, acc_nxt;

  logic                psum_ren_d;
  logic [ADDR_W-1:0]   psum_addr_d;
  logic                out_valid_d;
  logic [DATA_W-1:0]   out_data_d;
  logic [ONIJ_W-1:0]   out_addr_d;
  logic                busy_d;
  logic                done_d;
  logic [PSUM_BW-1:0]  out_lane;

  // Memory address of kernel tap k for output pixel onij: k*36 + input-tile nij.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ONIJ_W-1:0] onij,
                                                 input logic [KIJ_W-1:0]  k);
    logic [ADDR_W-1:0] kk, k_row, k_col, o_row, o_col;
    kk = ADDR_W'(k);
    if (kk >= ADDR_W'(6)) begin
      k_row = ADDR_W'(2);
    end else if (kk >= ADDR_W'(3)) begin
      k_row = ADDR_W'(1);
    end else begin
      k_row = '0;
    end
    k_col = kk - ADDR_W'(3) * k_row;
    o_row = ADDR_W'(onij[3:2]);
    o_col = ADDR_W'(onij[1:0]);
    return kk * ADDR_W'(36) + (o_row + k_row) * ADDR_W'(6) + o_col + k_col;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      kij       <= '0;
      o_nij     <= '0;
      relu_q    <= 1'b0;
      psum_ren  <= 1'b0;
      psum_addr <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      kij       <= kij_nxt;
      o_nij     <= o_nij_nxt;
      relu_q    <= relu_nxt;
      psum_ren  <= psum_ren_d;
      psum_addr <= psum_addr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_addr  <= out_addr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next state and tap/pixel counter sequencing.
  always_comb begin
    state_nxt = state;
    kij_nxt   = kij;
    o_nij_nxt = o_nij;
    relu_nxt  = relu_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
          kij_nxt   = '0;
          o_nij_nxt = '0;
          relu_nxt  = relu_en;
        end
      end
      READ: begin
        if (kij == KIJ_LAST) begin
          state_nxt = DRAIN;
          kij_nxt   = '0;
        end else begin
          kij_nxt = kij + KIJ_W'(1);
        end
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          if (o_nij == ONIJ_LAST) begin
            state_nxt = DONE;
          end else begin
            o_nij_nxt = o_nij + ONIJ_W'(1);
            state_nxt = READ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode for the upcoming cycle, registered in the state process.
  always_comb begin
    psum_ren_d  = 1'b0;
    psum_addr_d = '0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_addr_d  = '0;
    busy_d      = (state_nxt != IDLE);
    done_d      = 1'b0;
    out_lane    = '0;
    case (state_nxt)
      READ: begin
        psum_ren_d  = 1'b1;
        psum_addr_d = tap_addr(o_nij_nxt, kij_nxt);
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_addr_d  = o_nij_nxt;
        for (int unsigned l = 0; l < COL; l++) begin
          out_lane = acc_nxt[l*PSUM_BW +: PSUM_BW];
          out_data_d[l*PSUM_BW +: PSUM_BW] = (relu_nxt && out_lane[PSUM_BW-1]) ? '0 : out_lane;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Track which read returns this cycle; the accumulator follows the returned data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_first <= 1'b0;
      acc      <= '0;
    end else begin
      rd_pend  <= (state == READ);
      rd_first <= (state == READ) && (kij == '0);
      acc      <= acc_nxt;
    end
  end

  // Lane-wise wrap-around accumulation; first tap of a pixel overwrites.
  always_comb begin
    acc_nxt = acc;
    if (rd_pend) begin
      for (int unsigned l = 0; l < COL; l++) begin
        if (rd_first) begin
          acc_nxt[l*PSUM_BW +: PSUM_BW] = psum_rdata[l*PSUM_BW +: PSUM_BW];
        end else begin
          acc_nxt[l*PSUM_BW +: PSUM_BW] = acc[l*PSUM_BW +: PSUM_BW] + psum_rdata[l*PSUM_BW +: PSUM_BW];
        end
      end
    end
  end

endmodule

// File: doc/onij_gather_sequencer.md
ONIJ_GATHER_SEQUENCER -- requirements
Module: onij_gather_sequencer

Interface
REQ-001 Parameter: COL, default 8, number of psum lanes per memory word.
REQ-002 Parameter: PSUM_BW, default 16, bit width of each signed psum lane.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  synchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle pulse; begins a full 16-output gather pass.
REQ-006 Port: relu_en  input  1  apply ReLU per lane to the emitted output; sampled with start.
REQ-007 Port: psum_ren  output  1  psum memory read enable.
REQ-008 Port: psum_addr  output  9  psum memory address = kij*36 + nij.
REQ-009 Port: psum_rdata  input  COL*PSUM_BW  read data; valid exactly 1 cycle after psum_ren; lane i at bits [i*PSUM_BW +: PSUM_BW].
REQ-010 Port: out_valid  output  1  out_data/out_addr hold a finished output.
REQ-011 Port: out_ready  input  1  consumer accepts output when out_valid && out_ready.
REQ-012 Port: out_data  output  COL*PSUM_BW  accumulated output vector, same lane packing.
REQ-013 Port: out_addr  output  4  output index o_nij, 0..15.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse after the 16th output is accepted.

Function
REQ-016 Geometry fixed: 6x6 input tile, 3x3 kernel, 4x4 output; o_row=o_nij/4, o_col=o_nij%4, k_row=kij/3, k_col=kij%3.
REQ-017 For each (o_nij, kij): nij = (o_row+k_row)*6 + (o_col+k_col); every generated nij is in 0..35, no bounds check needed.
REQ-018 States: IDLE, READ, DRAIN, OUT, DONE.
REQ-019 IDLE: start=1 -> READ with o_nij=0, kij=0, relu_en latched; start ignored in all other states.
REQ-020 READ: psum_ren=1, psum_addr per REQ-008/017 for current (o_nij,kij); kij increments each cycle; at kij=8 -> DRAIN, kij resets to 0.
REQ-021 Accumulator: on the cycle data for kij=0 returns, acc loads psum_rdata; for kij=1..8 acc += psum_rdata per lane.
REQ-022 Per-lane addition signed, PSUM_BW bits, two's-complement wrap, no saturation, no carry between lanes.
REQ-023 DRAIN: psum_ren=0; accumulate kij=8 data; -> OUT.
REQ-024 OUT: out_valid=1; out_addr=o_nij; out_data=acc, each lane forced to 0 if negative when relu_en latched; out_data/out_addr stable while out_valid && !out_ready.
REQ-025 OUT with out_ready=1: o_nij<15 -> o_nij+1, READ next cycle; o_nij=15 -> DONE.
REQ-026 DONE: done=1 for one cycle, -> IDLE.
REQ-027 Minimum per-output cost 11 cycles (9 READ + 1 DRAIN + 1 OUT); full pass min 176 cycles + DONE.
REQ-028 psum_ren=0 in IDLE, DRAIN, OUT, DONE; psum_addr=0 whenever psum_ren=0.
REQ-029 out_ready while out_valid=0 has no effect.

Reset
REQ-030 reset_n=0 at a clock edge -> state IDLE, o_nij=0, kij=0, acc=0, latched relu_en=0.
REQ-031 During reset and the first cycle after: psum_ren=0, psum_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-032 Reset mid-pass aborts immediately; no out_valid or done is produced for the aborted pass; read data returning after reset is ignored.

Verification
REQ-033 start, out_ready=1: first 9 psum_addr = 0,1,2,6,7,8,12,13,14 (shifted by kij*36: 0,37,74,114,151,188,228,265,302); out_addr sequence 0..15; done after 16th accept.
REQ-034 o_nij=15 reads: nij 21,22,23,27,28,29,33,34,35 -> addr 21,58,95,135,172,209,249,286,323.
REQ-035 Memory lane0 = kij+1 at all nij, relu_en=0 -> every out_data lane0 = 45; lane1 = -1 every read -> lane1 = -9 (0xFFF7).
REQ-036 Same with relu_en=1 -> lane1 = 0, lane0 = 45; overflow case lane=0x7FFF for 2 reads then 0 -> 0xFFFE wrap (relu_en=0).
REQ-037 out_ready held low 5 cycles in OUT -> out_valid, out_data, out_addr constant, psum_ren=0; sequence resumes on ready.
REQ-038 reset_n=0 during READ of o_nij=7 -> all outputs per REQ-031, busy=0; subsequent start restarts at o_nij=0 addr 0.
